dac_spi_drive: RTL and testbench

Serial driver for the APD high-voltage bias DAC, directly downstream of the temperature-compensation stage, which produces a one-cycle `o_dac_start` strobe and a 10-bit `o_dac_value`. On each accepted request the block latches the code and shifts a 16-bit frame, MSB first, to the DAC over a 3-wire SPI link. It then pulses LDAC_n to update the DAC output and reports completion. A request that arrives mid-transfer is queued in a one-deep slot; the latest request wins.

---
 rtl/dac_spi_drive.sv | 231 +++++++++++++++++++++++
 tb/tb_dac_spi_drive.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_drive.sv
// -----------------------------------------------------------------------------
// dac_spi_drive
//   Serial driver for the APD high-voltage bias DAC. Each accepted request
//   latches a 10-bit code and shifts the 16-bit frame {CTRL_BITS, code, 2'b00}
//   MSB first over a 3-wire SPI link. It then pulses LDAC_n and reports
//   completion. A request that arrives while a transfer is running is parked in
//   a one-deep pending slot, where a later request replaces an earlier one.
//
// Parameters
//   CLK_DIV    SCLK half-period in i_clk_50m cycles (1..255)
//   CTRL_BITS  control nibble placed in frame bits [15:12]
//
// Ports
//   i_clk_50m     in   system clock
//   i_rst_n       in   asynchronous active-low reset
//   i_dac_start   in   one-cycle write request
//   i_dac_value   in   [9:0] DAC code, sampled together with i_dac_start
//   o_dac_cs_n    out  SPI chip select, active low
//   o_dac_sclk    out  SPI clock, idles low
//   o_dac_mosi    out  SPI data
//   o_dac_ldac_n  out  DAC load strobe, active low
//   o_busy        out  high in SHIFT/HOLD/LOAD
//   o_done        out  one-cycle pulse when a frame has been loaded
//   o_dac_last    out  [9:0] last code fully loaded into the DAC
// -----------------------------------------------------------------------------
module dac_spi_drive #(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] CTRL_BITS = 4'b0100
) (
    input  logic       i_clk_50m,
    input  logic       i_rst_n,
    input  logic       i_dac_start,
    input  logic [9:0] i_dac_value,
    output logic       o_dac_cs_n,
    output logic       o_dac_sclk,
    output logic       o_dac_mosi,
    output logic       o_dac_ldac_n,
    output logic       o_busy,
    output logic       o_done,
    output logic [9:0] o_dac_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);

    state_t      state_q,    state_d;
    logic [7:0]  phase_q,    phase_d;
    logic [3:0]  bit_q,      bit_d;
    logic        hi_q,       hi_d;       // 0: SCLK low phase, 1: high phase
    logic [15:0] shreg_q,    shreg_d;
    logic [9:0]  code_q,     code_d;     // code of the frame in flight
    logic        pend_q,     pend_d;
    logic [9:0]  pend_val_q, pend_val_d;
    logic [9:0]  last_q,     last_d;

    logic        cs_n_d, sclk_d, mosi_d, ldac_n_d, busy_d, done_d;
    logic        ph_end;

    // ------------------------------------------------------------------
    // State register (also carries the datapath and output flops)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            hi_q         <= 1'b0;
            shreg_q      <= '0;
            code_q       <= '0;
            pend_q       <= 1'b0;
            pend_val_q   <= '0;
            last_q       <= '0;
            o_dac_cs_n   <= 1'b1;
            o_dac_sclk   <= 1'b0;
            o_dac_mosi   <= 1'b0;
            o_dac_ldac_n <= 1'b1;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            hi_q         <= hi_d;
            shreg_q      <= shreg_d;
            code_q       <= code_d;
            pend_q       <= pend_d;
            pend_val_q   <= pend_val_d;
            last_q       <= last_d;
            o_dac_cs_n   <= cs_n_d;
            o_dac_sclk   <= sclk_d;
            o_dac_mosi   <= mosi_d;
            o_dac_ldac_n <= ldac_n_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
        end
    end

    assign o_dac_last = last_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        hi_d       = hi_q;
        shreg_d    = shreg_q;
        code_d     = code_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        last_d     = last_q;
        ph_end     = (phase_q == PH_LAST);

        // Any request outside IDLE lands in the pending slot; DONE consumes
        // it below in the same cycle.
        if (i_dac_start && (state_q != S_IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = i_dac_value;
        end

        case (state_q)
            S_IDLE: begin
                if (i_dac_start) begin
                    state_d = S_SHIFT;
                    code_d  = i_dac_value;
                    shreg_d = {CTRL_BITS, i_dac_value, 2'b00};
                    phase_d = '0;
                    bit_d   = 4'd15;
                    hi_d    = 1'b0;
                end
            end

            S_SHIFT: begin
                if (ph_end) begin
                    phase_d = '0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        hi_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            // Shift register is left alone so HOLD keeps bit 0 on MOSI.
                            state_d = S_HOLD;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (ph_end) begin
                    phase_d = '0;
                    state_d = S_LOAD;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            S_LOAD: begin
                if (ph_end) begin
                    phase_d = '0;
                    state_d = S_DONE;
                    last_d  = code_q;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            S_DONE: begin
                if (i_dac_start || pend_q) begin
                    // A start in this very cycle is newer than the parked one.
                    code_d  = i_dac_start ? i_dac_value : pend_val_q;
                    shreg_d = {CTRL_BITS, code_d, 2'b00};
                    state_d = S_SHIFT;
                    phase_d = '0;
                    bit_d   = 4'd15;
                    hi_d    = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: computed from the next state so the output flops
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        cs_n_d   = 1'b1;
        sclk_d   = 1'b0;
        mosi_d   = 1'b0;
        ldac_n_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            S_SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = hi_d;
                mosi_d = shreg_d[15];
                busy_d = 1'b1;
            end
            S_HOLD: begin
                cs_n_d = 1'b0;
                mosi_d = shreg_d[15];
                busy_d = 1'b1;
            end
            S_LOAD: begin
                ldac_n_d = 1'b0;
                busy_d   = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dac_spi_drive.sv
module tb_dac_spi_drive;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sel = 1'b0;      // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
    logic [9:0] val = '0;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    logic start4, start1;
    assign start4 = start & ~sel;
    assign start1 = start & sel;

    logic       cs4, sclk4, mosi4, ldac4, busy4, done4;
    logic [9:0] last4;
    logic       cs1, sclk1, mosi1, ldac1, busy1, done1;
    logic [9:0] last1;

    dac_spi_drive #(.CLK_DIV(4), .CTRL_BITS(4'b0100)) dut4 (
        .i_clk_50m(clk), .i_rst_n(rst_n), .i_dac_start(start4), .i_dac_value(val),
        .o_dac_cs_n(cs4), .o_dac_sclk(sclk4), .o_dac_mosi(mosi4), .o_dac_ldac_n(ldac4),
        .o_busy(busy4), .o_done(done4), .o_dac_last(last4)
    );

    dac_spi_drive #(.CLK_DIV(1), .CTRL_BITS(4'b0100)) dut1 (
        .i_clk_50m(clk), .i_rst_n(rst_n), .i_dac_start(start1), .i_dac_value(val),
        .o_dac_cs_n(cs1), .o_dac_sclk(sclk1), .o_dac_mosi(mosi1), .o_dac_ldac_n(ldac1),
        .o_busy(busy1), .o_done(done1), .o_dac_last(last1)
    );

    logic       s_cs, s_sclk, s_mosi, s_ldac, s_busy, s_done;
    logic [9:0] s_last;
    assign s_cs   = sel ? cs1   : cs4;
    assign s_sclk = sel ? sclk1 : sclk4;
    assign s_mosi = sel ? mosi1 : mosi4;
    assign s_ldac = sel ? ldac1 : ldac4;
    assign s_busy = sel ? busy1 : busy4;
    assign s_done = sel ? done1 : done4;
    assign s_last = sel ? last1 : last4;

    // Observes one frame from T1 to its done pulse (sampled on negedges).
    // Up to two extra requests can be injected at given frame cycles.
    task automatic run_frame(
        input  bit          do_start,
        input  logic [9:0]  code,
        input  int          inj_c1,
        input  logic [9:0]  inj_v1,
        input  int          inj_c2,
        input  logic [9:0]  inj_v2,
        output int          t_done,
        output logic [15:0] frame,
        output int          edges,
        output int          cs_low,
        output int          cs_hi,
        output int          ldac_low,
        output int          sclk_hi,
        output int          bad,
        output bit          busy_t1,
        output bit          busy_done,
        output logic [9:0]  last
    );
        bit prev_sclk = 1'b0;
        t_done = 0; frame = '0; edges = 0; cs_low = 0; cs_hi = 0;
        ldac_low = 0; sclk_hi = 0; bad = 0; busy_t1 = 1'b0; busy_done = 1'b1; last = '0;
        if (do_start) begin
            start = 1'b1;
            val   = code;
        end
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c > 1) begin
                @(negedge clk);
                start = 1'b0;
            end
            if (c == 1) busy_t1 = s_busy;
            if (s_sclk && !prev_sclk) begin
                frame = {frame[14:0], s_mosi};
                edges++;
            end
            prev_sclk = s_sclk;
            if (!s_cs) cs_low++; else cs_hi++;
            if (!s_ldac) begin
                ldac_low++;
                if (!s_cs) bad++;
            end
            if (s_sclk) begin
                sclk_hi++;
                if (s_cs) bad++;
            end
            if (c == inj_c1) begin start = 1'b1; val = inj_v1; end
            if (c == inj_c2) begin start = 1'b1; val = inj_v2; end
            if (s_done) begin
                t_done    = c;
                busy_done = s_busy;
                last      = s_last;
                break;
            end
        end
    endtask

    int          t_done, edges, cs_low, cs_hi, ldac_low, sclk_hi, bad;
    logic [15:0] frame;
    bit          busy_t1, busy_done;
    logic [9:0]  last;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs4, sclk4, mosi4, ldac4, busy4, done4} !== 6'b100100) begin
            failures++;
            $display("FAIL reset_outs4 got=%b exp=100100", {cs4, sclk4, mosi4, ldac4, busy4, done4});
        end
        checks++;
        if (last4 !== 10'd0) begin
            failures++;
            $display("FAIL reset_last4 got=%h exp=000", last4);
        end
        checks++;
        if ({cs1, sclk1, mosi1, ldac1, busy1, done1} !== 6'b100100) begin
            failures++;
            $display("FAIL reset_outs1 got=%b exp=100100", {cs1, sclk1, mosi1, ldac1, busy1, done1});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        sel = 1'b0;
        run_frame(1'b1, 10'h2A5, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (t_done !== 137) begin failures++; $display("FAIL single_done_cycle got=%0d exp=137", t_done); end
        checks++;
        if (frame !== 16'h4A94) begin failures++; $display("FAIL single_frame got=%h exp=4a94", frame); end
        checks++;
        if (edges !== 16) begin failures++; $display("FAIL single_edges got=%0d exp=16", edges); end
        checks++;
        if (cs_low !== 132) begin failures++; $display("FAIL single_cs_low got=%0d exp=132", cs_low); end
        checks++;
        if (ldac_low !== 4) begin failures++; $display("FAIL single_ldac_low got=%0d exp=4", ldac_low); end
        checks++;
        if (sclk_hi !== 64) begin failures++; $display("FAIL single_sclk_hi got=%0d exp=64", sclk_hi); end
        checks++;
        if (last !== 10'h2A5) begin failures++; $display("FAIL single_last got=%h exp=2a5", last); end
        checks++;
        if (busy_t1 !== 1'b1 || busy_done !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b%b exp=10", busy_t1, busy_done);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL single_protocol got=%0d exp=0", bad); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pending();
        int extra_done = 0;
        int extra_busy = 0;
        sel = 1'b0;
        run_frame(1'b1, 10'h155, 20, 10'h100, 60, 10'h3FF, t_done, frame, edges, cs_low,
                  cs_hi, ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (frame !== 16'h4554 || t_done !== 137) begin
            failures++;
            $display("FAIL pend_first got=%h/%0d exp=4554/137", frame, t_done);
        end
        checks++;
        if (cs_hi !== 5) begin failures++; $display("FAIL pend_cs_gap got=%0d exp=5", cs_hi); end
        run_frame(1'b0, '0, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (frame !== 16'h4FFC) begin failures++; $display("FAIL pend_second_frame got=%h exp=4ffc", frame); end
        checks++;
        if (busy_t1 !== 1'b1 || cs_low !== 132) begin
            failures++;
            $display("FAIL pend_second_start got=%b/%0d exp=1/132", busy_t1, cs_low);
        end
        checks++;
        if (last !== 10'h3FF || t_done !== 137) begin
            failures++;
            $display("FAIL pend_second_last got=%h/%0d exp=3ff/137", last, t_done);
        end
        repeat (20) begin
            @(negedge clk);
            if (s_done) extra_done++;
            if (s_busy) extra_busy++;
        end
        checks++;
        if (extra_done !== 0 || extra_busy !== 0) begin
            failures++;
            $display("FAIL pend_no_third got=%0d/%0d exp=0/0", extra_done, extra_busy);
        end
    endtask

    task automatic test_done_coincident();
        sel = 1'b0;
        run_frame(1'b1, 10'h0AA, 137, 10'h2C3, 0, '0, t_done, frame, edges, cs_low,
                  cs_hi, ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (busy_done !== 1'b0 || last !== 10'h0AA) begin
            failures++;
            $display("FAIL coinc_first got=%b/%h exp=0/0aa", busy_done, last);
        end
        run_frame(1'b0, '0, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (busy_t1 !== 1'b1) begin failures++; $display("FAIL coinc_busy_gap got=%b exp=1", busy_t1); end
        checks++;
        if (frame !== 16'h4B0C || last !== 10'h2C3) begin
            failures++;
            $display("FAIL coinc_second got=%h/%h exp=4b0c/2c3", frame, last);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int ldac_seen = 0;
        sel   = 1'b0;
        start = 1'b1;
        val   = 10'h1E7;
        @(negedge clk);
        start = 1'b0;
        repeat (65) @(negedge clk);     // frame cycle T66: bit 7 low phase
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs4, sclk4, mosi4, ldac4, busy4, done4} !== 6'b100100) begin
            failures++;
            $display("FAIL midrst_outs got=%b exp=100100", {cs4, sclk4, mosi4, ldac4, busy4, done4});
        end
        checks++;
        if (last4 !== 10'd0) begin failures++; $display("FAIL midrst_last got=%h exp=000", last4); end
        repeat (4) begin
            @(negedge clk);
            if (!ldac4) ldac_seen++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (!ldac4 || busy4) ldac_seen++;
        end
        checks++;
        if (ldac_seen !== 0) begin failures++; $display("FAIL midrst_quiet got=%0d exp=0", ldac_seen); end
        run_frame(1'b1, 10'h1E7, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (frame !== 16'h479C || t_done !== 137 || last !== 10'h1E7) begin
            failures++;
            $display("FAIL midrst_clean got=%h/%0d/%h exp=479c/137/1e7", frame, t_done, last);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clkdiv1();
        sel = 1'b1;
        run_frame(1'b1, 10'h3FF, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (t_done !== 35) begin failures++; $display("FAIL d1_done_cycle got=%0d exp=35", t_done); end
        checks++;
        if (frame !== 16'h4FFC || edges !== 16) begin
            failures++;
            $display("FAIL d1_frame got=%h/%0d exp=4ffc/16", frame, edges);
        end
        checks++;
        if (sclk_hi !== 16 || cs_low !== 33 || ldac_low !== 1) begin
            failures++;
            $display("FAIL d1_timing got=%0d/%0d/%0d exp=16/33/1", sclk_hi, cs_low, ldac_low);
        end
        checks++;
        if (last !== 10'h3FF || cs_hi !== 2) begin
            failures++;
            $display("FAIL d1_last got=%h/%0d exp=3ff/2", last, cs_hi);
        end
        repeat (3) @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_frame(1'b1, 10'h000, 10, 10'h3FF, 0, '0, t_done, frame, edges, cs_low,
                  cs_hi, ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (frame !== 16'h4000 || bad !== 0) begin
            failures++;
            $display("FAIL b2b_first got=%h/%0d exp=4000/0", frame, bad);
        end
        run_frame(1'b0, '0, 0, '0, 0, '0, t_done, frame, edges, cs_low, cs_hi,
                  ldac_low, sclk_hi, bad, busy_t1, busy_done, last);
        checks++;
        if (frame !== 16'h4FFC || bad !== 0 || last !== 10'h3FF) begin
            failures++;
            $display("FAIL b2b_second got=%h/%0d/%h exp=4ffc/0/3ff", frame, bad, last);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_pending();
        test_done_coincident();
        test_reset_midframe();
        test_clkdiv1();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
